cache_replacement_unit: RTL and testbench

CACHE_REPLACEMENT_UNIT -- requirements
Module: cache_replacement_unit

---
 rtl/cache_replacement_unit_if.sv | 34 +++
 rtl/cache_replacement_unit.sv | 120 ++++++++++++
 tb/tb_cache_replacement_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_replacement_unit_if.sv
// Replacement-unit bus: victim lookup, eviction commit, hit notification
// and flush, bundled so a cache controller connects through one port.
//
// There is no valid/ready handshake on this bus. evict_req, access_req and
// flush are single-cycle commands and are always accepted on the rising
// edge where they are high. victim_way and victim_invalid are
// combinational answers for the set_idx and valid_mask of the same cycle.
interface cache_replacement_unit_if #(
   parameter int SETS = 4,
   parameter int WAYS = 4
);
   localparam int SET_BITS = (SETS > 1) ? $clog2(SETS) : 1;
   localparam int WAY_BITS = $clog2(WAYS);

   logic                flush;
   logic [SET_BITS-1:0] set_idx;
   logic [WAYS-1:0]     valid_mask;
   logic                evict_req;
   logic                access_req;
   logic [SET_BITS-1:0] access_set;
   logic [WAY_BITS-1:0] access_way;
   logic [WAY_BITS-1:0] victim_way;
   logic                victim_invalid;

   modport master (
      output flush, set_idx, valid_mask, evict_req, access_req, access_set, access_way,
      input  victim_way, victim_invalid
   );

   modport slave (
      input  flush, set_idx, valid_mask, evict_req, access_req, access_set, access_way,
      output victim_way, victim_invalid
   );
endinterface

// File: rtl/cache_replacement_unit.sv
// Cache replacement unit. It picks a victim way for the addressed set with
// zero latency. An invalid way is always preferred. Among valid ways the
// choice follows either a per-set round-robin pointer (POLICY=0) or a
// per-set tree pseudo-LRU (POLICY=1). Reset and flush clear all state.
module cache_replacement_unit #(
   parameter int SETS   = 4,
   parameter int WAYS   = 4,
   parameter int POLICY = 0
) (
   input logic                    clk,
   input logic                    reset,
   cache_replacement_unit_if.slave bus
);
   localparam int WAY_BITS = $clog2(WAYS);

   logic [WAY_BITS-1:0] policy_way;
   logic [WAY_BITS-1:0] victim_sel;
   logic                victim_inv;

   // Victim select: the lowest-indexed invalid way overrides the policy choice.
   always_comb begin
      victim_sel = policy_way;
      victim_inv = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!bus.valid_mask[i]) begin
            victim_sel = WAY_BITS'(i);
            victim_inv = 1'b1;
         end
      end
   end

   assign bus.victim_way     = victim_sel;
   assign bus.victim_invalid = victim_inv;

   if (POLICY == 0) begin : g_rr
      logic [SETS-1:0][WAY_BITS-1:0] ptr_q, ptr_d;
      logic                          unused_access;

      // Hits carry no information for round-robin.
      assign unused_access = ^{bus.access_req, bus.access_set, bus.access_way};

      // Pointer update: advance only when a valid line is actually displaced.
      always_comb begin
         ptr_d = ptr_q;
         if (bus.flush) begin
            ptr_d = '0;
         end else if (bus.evict_req && !victim_inv) begin
            ptr_d[bus.set_idx] = ptr_q[bus.set_idx] + 1'b1;
         end
      end

      // Pointer register with synchronous reset.
      always_ff @(posedge clk) begin
         if (reset) ptr_q <= '0;
         else       ptr_q <= ptr_d;
      end

      assign policy_way = ptr_q[bus.set_idx];
   end else begin : g_plru
      localparam int TREE_W = WAYS - 1;

      logic [SETS-1:0][TREE_W-1:0] tree_q, tree_d;

      // Walk from the root: a 0 bit goes left, a 1 bit goes right. The
      // directions taken, MSB first, spell out the victim way index.
      function automatic logic [WAY_BITS-1:0] plru_walk(input logic [TREE_W-1:0] t);
         logic [WAY_BITS-1:0] node;
         logic [WAY_BITS-1:0] way;
         logic                dir;
         node = '0;
         way  = '0;
         for (int l = 0; l < WAY_BITS; l++) begin
            dir                = t[node];
            way[WAY_BITS-1-l]  = dir;
            node               = WAY_BITS'(32'(node) * 2 + 1 + 32'(dir));
         end
         return way;
      endfunction

      // Point every node on the path of w away from w. Other nodes are untouched.
      function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                       input logic [WAY_BITS-1:0] w);
         logic [TREE_W-1:0]   res;
         logic [WAY_BITS-1:0] node;
         logic                dir;
         res  = t;
         node = '0;
         for (int l = 0; l < WAY_BITS; l++) begin
            dir       = w[WAY_BITS-1-l];
            res[node] = ~dir;
            node      = WAY_BITS'(32'(node) * 2 + 1 + 32'(dir));
         end
         return res;
      endfunction

      // Tree update: the hit touch is applied first, then the evict touch,
      // so the evict wins on shared nodes when both address one set.
      always_comb begin
         tree_d = tree_q;
         if (bus.flush) begin
            tree_d = '0;
         end else begin
            if (bus.access_req) begin
               tree_d[bus.access_set] = plru_touch(tree_d[bus.access_set], bus.access_way);
            end
            if (bus.evict_req) begin
               tree_d[bus.set_idx] = plru_touch(tree_d[bus.set_idx], victim_sel);
            end
         end
      end

      // Tree register with synchronous reset.
      always_ff @(posedge clk) begin
         if (reset) tree_q <= '0;
         else       tree_q <= tree_d;
      end

      assign policy_way = plru_walk(tree_q[bus.set_idx]);
   end
endmodule

// File: tb/tb_cache_replacement_unit.sv
// Bench for cache_replacement_unit. One round-robin instance and one
// pseudo-LRU instance see the same stimulus. Both are compared with a
// range-based behavioural model of the replacement rules.
module tb_cache_replacement_unit;
   localparam int SETS = 4;
   localparam int WAYS = 4;
   localparam int WB   = 2;
   localparam int SB   = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_replacement_unit_if #(.SETS(SETS), .WAYS(WAYS)) bus_rr ();
   cache_replacement_unit_if #(.SETS(SETS), .WAYS(WAYS)) bus_pl ();

   cache_replacement_unit #(.SETS(SETS), .WAYS(WAYS), .POLICY(0)) dut_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_rr)
   );

   cache_replacement_unit #(.SETS(SETS), .WAYS(WAYS), .POLICY(1)) dut_pl (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_pl)
   );

   // ---------------- reference model + scoreboard ----------------
   int          rr_ptr  [SETS];
   bit          pl_tree [SETS][WAYS-1];
   logic [WB:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          rr_seq  [5];
   int          pl_seq  [4];
   int          pl_iso  [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic void model_clear();
      for (int s = 0; s < SETS; s++) begin
         rr_ptr[s] = 0;
         for (int n = 0; n < WAYS - 1; n++) pl_tree[s][n] = 1'b0;
      end
   endfunction

   function automatic int lowest_invalid(input logic [WAYS-1:0] mask);
      for (int i = 0; i < WAYS; i++) if (!mask[i]) return i;
      return -1;
   endfunction

   // Each node splits the way range [lo, lo+2*span) into two halves.
   function automatic int m_plru_victim(input int s);
      int n    = 0;
      int lo   = 0;
      int span = WAYS;
      while (span > 1) begin
         span = span / 2;
         if (pl_tree[s][n]) begin
            lo = lo + span;
            n  = 2 * n + 2;
         end else begin
            n  = 2 * n + 1;
         end
      end
      return lo;
   endfunction

   function automatic void m_plru_touch(input int s, input int w);
      int n    = 0;
      int lo   = 0;
      int span = WAYS;
      while (span > 1) begin
         span = span / 2;
         if (w < lo + span) begin
            pl_tree[s][n] = 1'b1;
            n = 2 * n + 1;
         end else begin
            pl_tree[s][n] = 1'b0;
            lo = lo + span;
            n  = 2 * n + 2;
         end
      end
   endfunction

   // ---------------- driver ----------------
   // Drives one cycle and checks both instances against the model mid-cycle.
   // The model is then committed, and the task returns just after the edge.
   // A want_* value of -1 skips the extra directed comparison.
   task automatic apply(input string tag, input int sidx, input logic [WAYS-1:0] mask,
                        input bit ev, input bit ac, input int aset, input int away,
                        input bit fl, input bit rst, input int want_rr, input int want_pl);
      int          inv;
      int          v_rr;
      int          v_pl;
      logic [WB:0] e;
      reset                 = rst;
      bus_rr.set_idx        = SB'(sidx);
      bus_rr.valid_mask     = mask;
      bus_rr.evict_req      = ev;
      bus_rr.access_req     = ac;
      bus_rr.access_set     = SB'(aset);
      bus_rr.access_way     = WB'(away);
      bus_rr.flush          = fl;
      bus_pl.set_idx        = SB'(sidx);
      bus_pl.valid_mask     = mask;
      bus_pl.evict_req      = ev;
      bus_pl.access_req     = ac;
      bus_pl.access_set     = SB'(aset);
      bus_pl.access_way     = WB'(away);
      bus_pl.flush          = fl;
      @(negedge clk);
      inv  = lowest_invalid(mask);
      v_rr = (inv >= 0) ? inv : rr_ptr[sidx];
      v_pl = (inv >= 0) ? inv : m_plru_victim(sidx);
      exp_q.push_back({inv >= 0, WB'(v_rr)});
      exp_q.push_back({inv >= 0, WB'(v_pl)});
      e = exp_q.pop_front();
      check({tag, "/rr"}, 32'({bus_rr.victim_invalid, bus_rr.victim_way}), 32'(e));
      e = exp_q.pop_front();
      check({tag, "/plru"}, 32'({bus_pl.victim_invalid, bus_pl.victim_way}), 32'(e));
      if (want_rr >= 0) check({tag, "/rr_directed"}, 32'(bus_rr.victim_way), want_rr);
      if (want_pl >= 0) check({tag, "/plru_directed"}, 32'(bus_pl.victim_way), want_pl);
      if (rst || fl) begin
         model_clear();
      end else begin
         if (ev && inv < 0) rr_ptr[sidx] = (rr_ptr[sidx] + 1) % WAYS;
         if (ac) m_plru_touch(aset, away);
         if (ev) m_plru_touch(sidx, v_pl);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply("reset", 0, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, -1, -1);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rr_seq = '{0, 1, 2, 3, 0};
      pl_seq = '{0, 2, 1, 3};
      pl_iso = '{0, 2, 0, 2};
      bus_rr.set_idx = '0; bus_rr.valid_mask = '1; bus_rr.evict_req = 1'b0;
      bus_rr.access_req = 1'b0; bus_rr.access_set = '0; bus_rr.access_way = '0;
      bus_rr.flush = 1'b0;
      bus_pl.set_idx = '0; bus_pl.valid_mask = '1; bus_pl.evict_req = 1'b0;
      bus_pl.access_req = 1'b0; bus_pl.access_set = '0; bus_pl.access_way = '0;
      bus_pl.flush = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();

      for (int s = 0; s < SETS; s++)
         apply("reset_state", s, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 5; k++)
         apply("rr_rotate", 2, 4'hF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, rr_seq[k], -1);
      apply("rr_other_set", 1, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, -1);

      do_reset();
      apply("invalid_way", 2, 4'b1011, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 2, 2);
      apply("rr_ptr_kept", 2, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, -1);

      do_reset();
      for (int k = 0; k < 4; k++)
         apply("plru_seq", 0, 4'hF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, -1, pl_seq[k]);

      do_reset();
      apply("plru_same_set", 0, 4'hF, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, -1, 0);
      apply("plru_same_next", 0, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, -1, 2);

      do_reset();
      apply("plru_diff_set", 3, 4'hF, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, -1, 0);
      for (int s = 0; s < SETS; s++)
         apply("plru_isolation", s, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, -1, pl_iso[s]);

      do_reset();
      for (int k = 0; k < 3; k++)
         apply("pre_reset_evict", 0, 4'hF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, k, -1);
      apply("reset_drops_evict", 0, 4'hF, 1'b1, 1'b1, 1, 2, 1'b0, 1'b1, 3, -1);
      reset = 1'b0;
      for (int s = 0; s < SETS; s++)
         apply("post_reset", s, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 3; k++)
         apply("pre_flush_evict", 0, 4'hF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, k, -1);
      apply("flush_drops_evict", 0, 4'hF, 1'b1, 1'b1, 2, 3, 1'b1, 1'b0, 3, -1);
      for (int s = 0; s < SETS; s++)
         apply("post_flush", s, 4'hF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 400; k++) begin
         logic [WAYS-1:0] mask;
         mask = ($urandom_range(0, 3) == 0) ? WAYS'($urandom_range(0, 15)) : 4'hF;
         apply("random", int'($urandom_range(0, SETS - 1)), mask,
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WAYS - 1)),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0), -1, -1);
         reset = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
